router_slice_buf: RTL and testbench
===================================

// Module: router_slice_buf
// PURPOSE
//  Parametrised, buffered stand-in for the router_wrap slot in NoC test fabrics.
//  Each input port has its own flit FIFO. FIFOs drain onto a fixed output-port
//  permutation chosen by MODE, and output ports use credit-based flow control.
//  Replaces the single-register pass-through slice with real buffering, credits
//  and error capture. The per-port wire format is unchanged.
// PARAMETERS
//  NUM_PORTS  5      router ports, 2..8
//  CHAN_W     69     channel bits per port: bit 0 of slice = valid, rest = payload
//  FC_W       2      flow-ctrl bits per port: bit 0 = credit, bit 1 = not-full
//  DEPTH      4      input FIFO entries per port, power of 2, >= 2
//  CREDITS    4      downstream buffer depth = initial/max credit count per output
//  ADDR_W     4      router_address width
//  MODE       2'b00  00 straight (ip i->op i); 01 reversed (ip i->op N-1-i);
//                    10 rotate (ip i->op (i+router_address) mod N); 11 = as 00
// PORTS
//  clk               in   1                 clock, all state on posedge
//  reset             in   1                 asynchronous, active-high
//  router_address    in   ADDR_W            rotation amount (MODE 10); quasi-static
//  channel_in_ip     in   NUM_PORTS*CHAN_W  port i = bits [i*CHAN_W +: CHAN_W]
//  flow_ctrl_out_ip  out  NUM_PORTS*FC_W    per input: credit pulse, not-full level
//  channel_out_op    out  NUM_PORTS*CHAN_W  per output: registered flit
//  flow_ctrl_in_op   in   NUM_PORTS*FC_W    per output: bit 0 = credit return; bit 1 ignored
//  error             out  1                 sticky error flag
// BEHAVIOUR
//  - Reset (async assert, sync release):
//    - all FIFOs empty; channel_out_op = 0; flow_ctrl_out_ip credit bits = 0
//    - not-full bits = 1; every credit counter = CREDITS; error = 0
//    - reset mid-packet discards buffered flits; no credits are returned for them.
//  - Push: valid flit on input i is written at the edge.
//    - Accepted if FIFO i is not full, or if a pop from FIFO i occurs in the same cycle.
//    - Otherwise the flit is dropped and error is set.
//  - Pop/send, per input i with target o = map(i):
//    - Condition: FIFO i non-empty AND credit[o] > 0.
//    - Head flit is registered onto channel_out_op port o (valid = 1).
//    - credit[o] decrements.
//    - flow_ctrl_out_ip[i] credit bit pulses high for exactly that cycle
//      (registered with the flit).
//  - If no send to port o in a cycle, channel_out_op port o is all zeros next cycle.
//  - Latency: flit sampled at edge t appears on channel_out_op after edge t+1
//    (2 cycles) when its FIFO was empty and credit is available.
//    FIFO order is preserved per port.
//  - The mapping is a permutation, so no output contention and no arbitration.
//    All ports may send in the same cycle.
//  - Credits: a credit-in on output o increments credit[o].
//    - Credit-in and send in the same cycle: count unchanged.
//    - Credit-in while count == CREDITS (and no send): count saturates and error is set.
//    - Counter width is clog2(CREDITS+1).
//  - Not-full bit i = registered (FIFO i occupancy < DEPTH).
//  - MODE 10: rotation = router_address mod NUM_PORTS, computed combinationally.
//    A change of router_address while flits are queued is unsupported.
//  - error is sticky; it is cleared only by reset.
// TESTING
//  1. MODE=00, N=5: flit 0x1_ABCD on ip2 at cycle 0 -> op2 carries it at cycle 2;
//     flow_ctrl_out_ip[2] credit bit pulses at cycle 2; credit[2] = 3.
//  2. MODE=01: flit on ip0 -> emerges on op4. MODE=10, router_address=7: ip4 -> op1.
//  3. Backpressure: 6 flits into ip1 with no credit returns -> 4 sent;
//     after the 4th push the FIFO holds the rest; not-full drops at 4 occupancy;
//     2 credit-ins -> remaining 2 sent in order.
//  4. Overflow: fill FIFO 3 (DEPTH=4) with credit[3]=0, then push a 5th flit
//     -> flit dropped, error = 1 and stays 1.
//  5. Credit return when credit[0] = CREDITS -> count stays 4, error = 1.
//     Credit-in and send in the same cycle -> count unchanged, no error.
//  6. Assert reset mid-stream with 3 flits queued -> outputs 0 immediately
//     (async clear); after release, credits = 4, FIFOs empty, no stale flits emitted.

Source files
------------

// File: rtl/router_slice_buf.sv
// Buffered router slot stand-in: per-input flit FIFOs drain onto a fixed output
// permutation chosen by MODE, with per-output credit counters and a sticky error flag.
module router_slice_buf #(
  parameter int unsigned NUM_PORTS = 5,
  parameter int unsigned CHAN_W    = 69,
  parameter int unsigned FC_W      = 2,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned CREDITS   = 4,
  parameter int unsigned ADDR_W    = 4,
  parameter logic [1:0]  MODE      = 2'b00
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ADDR_W-1:0]           router_address,
  input  logic [NUM_PORTS*CHAN_W-1:0] channel_in_ip,
  output logic [NUM_PORTS*FC_W-1:0]   flow_ctrl_out_ip,
  output logic [NUM_PORTS*CHAN_W-1:0] channel_out_op,
  input  logic [NUM_PORTS*FC_W-1:0]   flow_ctrl_in_op,
  output logic                        error
);

  localparam int unsigned PayW  = CHAN_W - 1;
  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = $clog2(DEPTH + 1);
  localparam int unsigned CrW   = $clog2(CREDITS + 1);
  localparam int unsigned PortW = $clog2(NUM_PORTS);

  logic [PayW-1:0]  mem_q    [NUM_PORTS][DEPTH];
  logic [PtrW-1:0]  wr_ptr_q [NUM_PORTS];
  logic [PtrW-1:0]  rd_ptr_q [NUM_PORTS];
  logic [CntW-1:0]  cnt_q    [NUM_PORTS];
  logic [CntW-1:0]  cnt_d    [NUM_PORTS];
  logic [CrW-1:0]   credit_q [NUM_PORTS];
  logic [CrW-1:0]   credit_d [NUM_PORTS];
  logic [PortW-1:0] dst      [NUM_PORTS];

  logic [NUM_PORTS-1:0] pulse_q, not_full_q, not_full_d;
  logic [NUM_PORTS-1:0] in_valid, credit_in, send, push, drop, sent_to;
  logic [NUM_PORTS*CHAN_W-1:0] out_q, out_d;
  logic error_q, error_d;

  // Only bit 0 of each returned flow-control slice carries meaning.
  logic unused_fc;
  assign unused_fc = ^flow_ctrl_in_op;

  // Fixed input->output permutation; rotation derived from router_address.
  always_comb begin
    int unsigned rot;
    rot = 32'(router_address) % NUM_PORTS;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      case (MODE)
        2'b01:   dst[i] = PortW'(NUM_PORTS - 1 - i);
        2'b10:   dst[i] = PortW'((i + rot) % NUM_PORTS);
        default: dst[i] = PortW'(i);
      endcase
    end
  end

  // Per-port push/pop decisions, output flit staging and credit bookkeeping.
  always_comb begin
    out_d   = '0;
    sent_to = '0;
    error_d = error_q;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      in_valid[i]  = channel_in_ip[i*CHAN_W];
      credit_in[i] = flow_ctrl_in_op[i*FC_W];
      send[i]      = (cnt_q[i] != '0) && (credit_q[dst[i]] != '0);
      // A full FIFO still accepts when its head leaves in the same cycle.
      push[i]      = in_valid[i] && ((cnt_q[i] != CntW'(DEPTH)) || send[i]);
      drop[i]      = in_valid[i] && !push[i];
      cnt_d[i]      = cnt_q[i] + CntW'(push[i]) - CntW'(send[i]);
      not_full_d[i] = (cnt_d[i] != CntW'(DEPTH));
      if (send[i]) begin
        sent_to[dst[i]] = 1'b1;
        out_d[dst[i]*CHAN_W +: CHAN_W] = {mem_q[i][rd_ptr_q[i]], 1'b1};
      end
      if (drop[i]) error_d = 1'b1;
    end
    for (int unsigned o = 0; o < NUM_PORTS; o++) begin
      credit_d[o] = credit_q[o];
      if (credit_in[o] && !sent_to[o]) begin
        if (credit_q[o] == CrW'(CREDITS)) error_d = 1'b1;
        else credit_d[o] = credit_q[o] + CrW'(1);
      end else if (sent_to[o] && !credit_in[o]) begin
        credit_d[o] = credit_q[o] - CrW'(1);
      end
    end
  end

  // Control state: pointers, occupancy, credits, registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
        credit_q[i] <= CrW'(CREDITS);
      end
      pulse_q    <= '0;
      not_full_q <= '1;
      out_q      <= '0;
      error_q    <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PtrW'(1);
        if (send[i]) rd_ptr_q[i] <= rd_ptr_q[i] + PtrW'(1);
        cnt_q[i]    <= cnt_d[i];
        credit_q[i] <= credit_d[i];
      end
      pulse_q    <= send;
      not_full_q <= not_full_d;
      out_q      <= out_d;
      error_q    <= error_d;
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= channel_in_ip[i*CHAN_W+1 +: PayW];
    end
  end

  // Pack per-input credit pulse and not-full level into the flow-control bus.
  always_comb begin
    flow_ctrl_out_ip = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      flow_ctrl_out_ip[i*FC_W]     = pulse_q[i];
      flow_ctrl_out_ip[i*FC_W + 1] = not_full_q[i];
    end
  end

  assign channel_out_op = out_q;
  assign error          = error_q;

endmodule

// File: tb/tb_router_slice_buf.sv
// Bench for router_slice_buf: three instances (straight, reversed, rotate by 7)
// checked every cycle against a queue-based model, plus directed literal checks.
module tb_router_slice_buf;

  localparam int NP      = 5;
  localparam int CW      = 69;
  localparam int PW      = 68;
  localparam int FW      = 2;
  localparam int DEPTH   = 4;
  localparam int CREDITS = 4;
  localparam int NI      = 3;
  localparam int ADDR2   = 7;

  logic clk = 1'b0;
  logic reset;
  logic [NP*CW-1:0] ch_in  [NI];
  logic [NP*FW-1:0] fc_in  [NI];
  logic [NP*CW-1:0] ch_out [NI];
  logic [NP*FW-1:0] fc_out [NI];
  logic             err    [NI];

  int n_assert = 0;
  int n_fail   = 0;

  // Model state
  logic [PW-1:0]    fq [NI][NP][$];
  int               cred    [NI][NP];
  logic [NP*CW-1:0] exp_ch  [NI];
  logic [NP*FW-1:0] exp_fc  [NI];
  logic             exp_err [NI];

  always #5 clk = ~clk;

  router_slice_buf #(.MODE(2'b00)) u_straight (
    .clk(clk), .reset(reset), .router_address(4'd0),
    .channel_in_ip(ch_in[0]), .flow_ctrl_out_ip(fc_out[0]),
    .channel_out_op(ch_out[0]), .flow_ctrl_in_op(fc_in[0]), .error(err[0])
  );
  router_slice_buf #(.MODE(2'b01)) u_reversed (
    .clk(clk), .reset(reset), .router_address(4'd0),
    .channel_in_ip(ch_in[1]), .flow_ctrl_out_ip(fc_out[1]),
    .channel_out_op(ch_out[1]), .flow_ctrl_in_op(fc_in[1]), .error(err[1])
  );
  router_slice_buf #(.MODE(2'b10)) u_rotate (
    .clk(clk), .reset(reset), .router_address(4'd7),
    .channel_in_ip(ch_in[2]), .flow_ctrl_out_ip(fc_out[2]),
    .channel_out_op(ch_out[2]), .flow_ctrl_in_op(fc_in[2]), .error(err[2])
  );

  function automatic int map_port(int k, int i);
    case (k)
      1:       return NP - 1 - i;
      2:       return (i + (ADDR2 % NP)) % NP;
      default: return i;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < NP; i++) begin
        fq[k][i].delete();
        cred[k][i] = CREDITS;
      end
      exp_ch[k]  = '0;
      exp_fc[k]  = {NP{2'b10}};
      exp_err[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k);
    logic             snd [NP];
    logic [NP*CW-1:0] nch;
    logic [NP*FW-1:0] nfc;
    logic             sent;
    int o;
    nch = '0;
    nfc = '0;
    for (int i = 0; i < NP; i++) begin
      o = map_port(k, i);
      snd[i] = (fq[k][i].size() > 0) && (cred[k][o] > 0);
      if (snd[i]) begin
        nch[o*CW +: CW] = {fq[k][i][0], 1'b1};
        nfc[i*FW] = 1'b1;
      end
    end
    for (int i = 0; i < NP; i++) begin
      if (snd[i]) void'(fq[k][i].pop_front());
      if (ch_in[k][i*CW]) begin
        if (fq[k][i].size() < DEPTH) fq[k][i].push_back(ch_in[k][i*CW+1 +: PW]);
        else exp_err[k] = 1'b1;
      end
      nfc[i*FW+1] = (fq[k][i].size() < DEPTH);
    end
    for (int p = 0; p < NP; p++) begin
      sent = 1'b0;
      for (int i = 0; i < NP; i++) if (map_port(k, i) == p && snd[i]) sent = 1'b1;
      if (fc_in[k][p*FW] && !sent) begin
        if (cred[k][p] == CREDITS) exp_err[k] = 1'b1;
        else cred[k][p]++;
      end else if (sent && !fc_in[k][p*FW]) begin
        cred[k][p]--;
      end
    end
    exp_ch[k] = nch;
    exp_fc[k] = nfc;
  endtask

  // Model advances on the same edges as the DUTs.
  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else for (int k = 0; k < NI; k++) model_step(k);
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      n_assert += 3;
      if (ch_out[k] !== exp_ch[k]) begin
        n_fail++;
        $display("FAIL cmp_chan inst%0d t=%0t got %h want %h", k, $time, ch_out[k], exp_ch[k]);
      end
      if (fc_out[k] !== exp_fc[k]) begin
        n_fail++;
        $display("FAIL cmp_fc inst%0d t=%0t got %h want %h", k, $time, fc_out[k], exp_fc[k]);
      end
      if (err[k] !== exp_err[k]) begin
        n_fail++;
        $display("FAIL cmp_err inst%0d t=%0t got %b want %b", k, $time, err[k], exp_err[k]);
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got %h want %h", name, $time, act, exp);
    end
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < NI; k++) begin
      ch_in[k] = '0;
      fc_in[k] = '0;
    end
  endtask

  // Advance one edge; inputs set before this call are seen for exactly that edge.
  task automatic tick();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic put(input int k, input int i, input logic [PW-1:0] p);
    ch_in[k][i*CW +: CW] = {p, 1'b1};
  endtask

  task automatic credit_ret(input int k, input int p);
    fc_in[k][p*FW] = 1'b1;
  endtask

  function automatic logic [CW-1:0] op(input int k, input int p);
    return ch_out[k][p*CW +: CW];
  endfunction

  logic [PW-1:0] pay;

  initial begin
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("reset_chan", 128'(|ch_out[0]), 128'd0);
    check("reset_fc", 128'(fc_out[0]), 128'h2AA);
    check("reset_err", 128'(err[0]), 128'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Straight: ip2 -> op2 two edges after sampling
    put(0, 2, 68'h1ABCD);
    tick();
    check("t1_not_yet", 128'(op(0, 2)), 128'd0);
    tick();
    check("t1_op2", 128'(op(0, 2)), {59'd0, 68'h1ABCD, 1'b1});
    check("t1_pulse", 128'(fc_out[0][2*FW]), 128'd1);
    check("t1_cred_model", 128'(cred[0][2]), 128'd3);
    tick();
    check("t1_op2_clear", 128'(op(0, 2)), 128'd0);
    check("t1_pulse_clear", 128'(fc_out[0][2*FW]), 128'd0);

    // Reversed ip0 -> op4; rotate by 7 mod 5 = 2: ip4 -> op1
    put(1, 0, 68'h22);
    put(2, 4, 68'h33);
    tick();
    tick();
    check("t2_rev_op4", 128'(op(1, 4)), {59'd0, 68'h22, 1'b1});
    check("t2_rev_op0", 128'(op(1, 0)), 128'd0);
    check("t2_rot_op1", 128'(op(2, 1)), {59'd0, 68'h33, 1'b1});
    tick();

    // Backpressure on ip1: 4 sent, 2 wait for credits
    for (int j = 0; j < 6; j++) begin
      put(0, 1, 68'h100 + 68'(j));
      tick();
      pay = 68'h100 + 68'(j - 1);
      if (j >= 1 && j <= 4) check("t3_stream", 128'(op(0, 1)), {59'd0, pay, 1'b1});
      else check("t3_stall", 128'(op(0, 1)), 128'd0);
    end
    tick();
    check("t3_still_stalled", 128'(op(0, 1)), 128'd0);
    credit_ret(0, 1);
    tick();
    check("t3_credit_latency", 128'(op(0, 1)), 128'd0);
    credit_ret(0, 1);
    tick();
    check("t3_fifth", 128'(op(0, 1)), {59'd0, 68'h104, 1'b1});
    tick();
    check("t3_sixth", 128'(op(0, 1)), {59'd0, 68'h105, 1'b1});
    tick();
    check("t3_drained", 128'(op(0, 1)), 128'd0);
    check("t3_cred_model", 128'(cred[0][1]), 128'd0);

    // Overflow on ip3 with credit[3] exhausted
    for (int j = 0; j < 8; j++) begin
      put(0, 3, 68'h300 + 68'(j));
      tick();
      if (j == 6) check("t4_nf_at3", 128'(fc_out[0][3*FW+1]), 128'd1);
      if (j == 7) check("t4_nf_at4", 128'(fc_out[0][3*FW+1]), 128'd0);
    end
    check("t4_err_before", 128'(err[0]), 128'd0);
    put(0, 3, 68'h308);
    tick();
    check("t4_err_set", 128'(err[0]), 128'd1);
    tick();
    tick();
    check("t4_err_sticky", 128'(err[0]), 128'd1);

    // Credit return together with a send leaves the count alone, no error
    put(2, 4, 68'h44);
    tick();
    credit_ret(2, 1);
    tick();
    check("t5_send", 128'(op(2, 1)), {59'd0, 68'h44, 1'b1});
    check("t5_no_err", 128'(err[2]), 128'd0);
    check("t5_cred_model", 128'(cred[2][1]), 128'd3);
    // Credit return at full count saturates and flags
    credit_ret(1, 0);
    tick();
    check("t5_sat_err", 128'(err[1]), 128'd1);
    tick();
    check("t5_sat_sticky", 128'(err[1]), 128'd1);

    // Reset mid-stream with three flits queued on ip1
    for (int j = 0; j < 3; j++) begin
      put(0, 1, 68'h500 + 68'(j));
      tick();
    end
    credit_ret(0, 3);
    tick();
    tick();
    check("t6_pre_reset", 128'(op(0, 3)), {59'd0, 68'h304, 1'b1});
    reset = 1'b1;
    #1;
    check("t6_async_chan", 128'(|ch_out[0]), 128'd0);
    check("t6_async_fc", 128'(fc_out[0]), 128'h2AA);
    check("t6_async_err", 128'(err[0]), 128'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int j = 0; j < 4; j++) begin
      tick();
      check("t6_no_stale", 128'(|ch_out[0]), 128'd0);
    end
    put(0, 1, 68'h600);
    tick();
    tick();
    check("t6_fresh", 128'(op(0, 1)), {59'd0, 68'h600, 1'b1});
    check("t6_cred_model", 128'(cred[0][1]), 128'd3);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
